reg_full: RTL and testbench



---
 rtl/reg_full_pkg.sv | 15 +
 rtl/reg_full_sync.sv | 29 ++
 rtl/reg_full.sv | 97 +++++++++
 tb/tb_reg_full.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/reg_full_pkg.sv
// Shared constants for the reg_full clock-ratio monitor.
// Holds the default parameter values and the counter saturation helper.
package reg_full_pkg;

    localparam int DEF_EXP_PERIOD = 4;
    localparam int DEF_TOL        = 0;
    localparam int DEF_FULL_COUNT = 8;
    localparam int DEF_CNT_W      = 8;

    // Largest value a width-bit period counter can hold before it saturates.
    function automatic int sat_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/reg_full_sync.sv
// Two-flop synchroniser plus rising-edge detector for the monitored clk.
// The monitored signal is data here; rise pulses for one fclk cycle per edge.
module reg_full_sync (
    input  logic fclk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic d;

    // Resynchronise din, then keep one extra delayed copy for edge detection.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            d  <= s2;
        end
    end

    assign rise = s2 & ~d;

endmodule

// File: rtl/reg_full.sv
// Clock-ratio monitor: measures each period of clk in fclk cycles and raises
// counter_check once FULL_COUNT consecutive periods land within TOL of EXP_PERIOD.
// Build option: define REGFULL_STICKY_EN to make counter_check hold until rst.
module reg_full
    import reg_full_pkg::*;
#(
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int FULL_COUNT = DEF_FULL_COUNT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic fclk,
    input  logic rst,
    input  logic clk,
    output logic counter_check
);

    localparam int GC_W = $clog2(FULL_COUNT + 1);

    localparam logic [CNT_W-1:0] PCNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] PCNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   MEAS_ONE = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]   EXP_W    = (CNT_W + 1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   TOL_W    = (CNT_W + 1)'(TOL);
    localparam logic [GC_W-1:0]  GC_FULL  = GC_W'(FULL_COUNT);
    localparam logic [GC_W-1:0]  GC_ONE   = GC_W'(1);

    logic             rise;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] pcnt_nxt;
    logic             armed;
    logic             armed_nxt;
    logic [GC_W-1:0]  good_cnt;
    logic [GC_W-1:0]  good_cnt_nxt;
    logic             check_nxt;
    logic             timeout;
    logic             good;
    logic [CNT_W:0]   meas;
    logic [CNT_W:0]   dev;

    reg_full_sync u_sync (
        .fclk (fclk),
        .rst  (rst),
        .din  (clk),
        .rise (rise)
    );

    // Period measurement, arming, good-period streak and the output decision.
    always_comb begin
        meas         = {1'b0, pcnt} + MEAS_ONE;
        dev          = (meas >= EXP_W) ? (meas - EXP_W) : (EXP_W - meas);
        timeout      = (pcnt == PCNT_MAX);
        // A saturated counter means the true period is unknown, so it can never be good.
        good         = !timeout && (dev <= TOL_W);
        pcnt_nxt     = timeout ? pcnt : (pcnt + PCNT_ONE);
        armed_nxt    = armed;
        good_cnt_nxt = good_cnt;

        if (rise) begin
            pcnt_nxt  = '0;
            armed_nxt = 1'b1;
            if (armed) begin
                if (!good) begin
                    good_cnt_nxt = '0;
                end else if (good_cnt != GC_FULL) begin
                    good_cnt_nxt = good_cnt + GC_ONE;
                end
            end
        end else if (timeout) begin
            // Stuck clk: drop the streak and require a fresh arming edge.
            good_cnt_nxt = '0;
            armed_nxt    = 1'b0;
        end

`ifdef REGFULL_STICKY_EN
        check_nxt = counter_check | (good_cnt_nxt == GC_FULL);
`else
        check_nxt = (good_cnt_nxt == GC_FULL);
`endif
    end

    // State and output registers.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            pcnt          <= '0;
            armed         <= 1'b0;
            good_cnt      <= '0;
            counter_check <= 1'b0;
        end else begin
            pcnt          <= pcnt_nxt;
            armed         <= armed_nxt;
            good_cnt      <= good_cnt_nxt;
            counter_check <= check_nxt;
        end
    end

endmodule

// File: tb/tb_reg_full.sv
// Testbench for reg_full: event-level reference model plus directed clk patterns.
module tb_reg_full;

    localparam int EXP_PERIOD = 4;
    localparam int TOL        = 0;
    localparam int FULL_COUNT = 8;
    localparam int CNT_W      = 8;
    localparam int MAX        = (1 << CNT_W) - 1;

`ifdef REGFULL_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic fclk;
    logic rst;
    logic clk;
    logic counter_check;

    int checks;
    int errors;

    reg_full #(
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .FULL_COUNT (FULL_COUNT),
        .CNT_W      (CNT_W)
    ) dut (
        .fclk          (fclk),
        .rst           (rst),
        .clk           (clk),
        .counter_check (counter_check)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    // Reference model: a rise is seen two fclk edges after clk is first sampled high;
    // the measured period is the number of fclk edges between consecutive seen rises.
    bit [3:0] hist;
    int       edge_no;
    int       last_rise;
    int       elapsed;
    int       dev_m;
    int       streak;
    bit       armed_m;
    bit       rise_m;
    bit       tmo_m;
    bit       exp_check;

    always @(posedge fclk or posedge rst) begin
        if (rst) begin
            hist      = '0;
            edge_no   = 0;
            last_rise = -1;
            streak    = 0;
            armed_m   = 1'b0;
            exp_check = 1'b0;
        end else begin
            hist    = {hist[2:0], clk};
            rise_m  = hist[2] && !hist[3];
            elapsed = edge_no - last_rise;
            tmo_m   = (elapsed - 1) >= MAX;
            dev_m   = (elapsed >= EXP_PERIOD) ? elapsed - EXP_PERIOD : EXP_PERIOD - elapsed;
            if (rise_m) begin
                if (armed_m) begin
                    if (!tmo_m && dev_m <= TOL)
                        streak = (streak + 1 > FULL_COUNT) ? FULL_COUNT : streak + 1;
                    else
                        streak = 0;
                end
                armed_m   = 1'b1;
                last_rise = edge_no;
            end else if (tmo_m) begin
                streak  = 0;
                armed_m = 1'b0;
            end
            exp_check = (STICKY && exp_check) || (streak == FULL_COUNT);
            edge_no++;
        end
    end

    // Every cycle: DUT output against the model.
    always @(negedge fclk) begin
        checks++;
        if (counter_check !== exp_check) begin
            errors++;
            $display("FAIL model_cmp t=%0t counter_check=%b expected=%b", $time, counter_check, exp_check);
        end
    end

    task automatic check_lit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t counter_check=%b expected=%b", name, $time, act, exp);
        end
    endtask

    // One clk period: high for hi fclk cycles, then low for the rest. Starts and ends on a negedge.
    task automatic drive_period(input int p, input int hi);
        clk = 1'b1;
        repeat (hi) @(negedge fclk);
        clk = 1'b0;
        repeat (p - hi) @(negedge fclk);
    endtask

    task automatic do_reset();
        clk = 1'b0;
        rst = 1'b1;
        @(negedge fclk);
        rst = 1'b0;
        repeat (4) @(negedge fclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clk    = 1'b0;
        @(negedge fclk);
        check_lit("reset_value", counter_check, 1'b0);

        // clk toggling every 20 ns while held in reset
        repeat (6) drive_period(4, 2);
        check_lit("in_reset", counter_check, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge fclk);

        // 40 ns clk: arming rise + 7 good is not enough, the 9th rise locks
        repeat (8) drive_period(4, 2);
        check_lit("arm_plus_7", counter_check, 1'b0);
        drive_period(4, 2);
        check_lit("lock_9th_rise", counter_check, 1'b1);
        repeat (4) drive_period(4, 2);
        check_lit("lock_hold", counter_check, 1'b1);

        // Off-ratio clocks never lock with TOL=0
        do_reset();
        repeat (12) drive_period(6, 3);
        check_lit("p6_no_lock", counter_check, 1'b0);
        repeat (12) drive_period(5, 2);
        check_lit("p5_no_lock", counter_check, 1'b0);
        repeat (12) drive_period(3, 1);
        check_lit("p3_no_lock", counter_check, 1'b0);

        // Lock, one 60 ns period, then back to 40 ns
        do_reset();
        repeat (9) drive_period(4, 2);
        check_lit("relock_base", counter_check, 1'b1);
        drive_period(6, 3);
        drive_period(4, 2);
        check_lit("bad_rise", counter_check, STICKY);
        repeat (7) drive_period(4, 2);
        check_lit("recover_7", counter_check, STICKY);
        drive_period(4, 2);
        check_lit("recover_8", counter_check, 1'b1);

        // Stuck clk: counter saturates, flag drops, restart needs re-arming
        clk = 1'b0;
        repeat (300) @(negedge fclk);
        check_lit("stuck_timeout", counter_check, STICKY);
        repeat (8) drive_period(4, 2);
        check_lit("restart_8", counter_check, STICKY);
        drive_period(4, 2);
        check_lit("restart_9", counter_check, 1'b1);

        // Asynchronous reset between fclk edges while locked
        #2;
        rst = 1'b1;
        #1;
        check_lit("async_rst", counter_check, 1'b0);
        @(negedge fclk);
        rst = 1'b0;
        repeat (4) @(negedge fclk);
        repeat (9) drive_period(4, 2);
        check_lit("post_rst_lock", counter_check, 1'b1);

        repeat (3) @(negedge fclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
